// File: rtl/mult.sv
// Sequential 16x16 unsigned shift-and-add multiplier with init_in/done handshake.
// Optional MULT_EARLY_EXIT_EN ends RUN once the remaining multiplier bits are all zero.
module mult (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_in,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] Result,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] reg_a_reg, reg_a_next;
  logic [15:0] reg_b_reg, reg_b_next;
  logic [31:0] acc_reg, acc_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic        last_step;

  // The final RUN edge: counter expiry, or no multiplier bits left to retire.
  always_comb begin
`ifdef MULT_EARLY_EXIT_EN
    last_step = (cnt_reg == 5'd1) || (reg_b_reg[15:1] == 15'd0);
`else
    last_step = (cnt_reg == 5'd1);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      reg_a_reg <= '0;
      reg_b_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      reg_a_reg <= reg_a_next;
      reg_b_reg <= reg_b_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (init_in) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    if (!init_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reg_a_next = reg_a_reg;
    reg_b_next = reg_b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (init_in) begin
          reg_a_next = {16'h0000, A};
          reg_b_next = B;
          acc_next   = '0;
          cnt_next   = 5'd16;
        end
      end
      RUN: begin
        if (reg_b_reg[0]) acc_next = acc_reg + reg_a_reg;
        reg_a_next = {reg_a_reg[30:0], 1'b0};
        reg_b_next = {1'b0, reg_b_reg[15:1]};
        cnt_next   = cnt_reg - 5'd1;
      end
      default: ;
    endcase
    // done is a flop so the consumer sees a clean flag aligned with the final acc.
    done_next = (state_next == DONE);
  end

  assign Result = acc_reg;
  assign done   = done_reg;

endmodule

// File: tb/tb_mult.sv
// Randomised self-checking bench for mult: spec-level model, per-cycle compare, directed pins.
module tb_mult;

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [31:0] result;
  logic        done;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  mult dut (
    .clk    (clk),
    .rst    (rst),
    .init_in(init_in),
    .A      (a),
    .B      (b),
    .Result (result),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Cycles from accepting edge to done, derived from the operand value.
  function automatic int exp_latency(input logic [15:0] bv);
    int hi;
    hi = -1;
    for (int i = 0; i < 16; i++) if (bv[i]) hi = i;
    if (!EE) return 16;
    return (hi + 1 < 1) ? 1 : hi + 1;
  endfunction

  // Behavioural model: phase flags, remaining-cycle count and the true product.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_prod = '0;
  logic [31:0] m_result = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_left   <= 0;
      m_result <= '0;
    end else if (m_done) begin
      if (!init_in) m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_result <= m_prod;
      end
    end else if (init_in) begin
      m_prod   <= {16'h0000, a} * {16'h0000, b};
      m_result <= '0;
      m_left   <= exp_latency(b);
      m_busy   <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      total++;
      if (done !== m_done) begin
        bad++;
        $display("FAIL cycle_done t=%0t actual=%b expected=%b", $time, done, m_done);
      end
      if (!m_busy) begin
        total++;
        if (result !== m_result) begin
          bad++;
          $display("FAIL cycle_result t=%0t actual=%h expected=%h", $time, result, m_result);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE, returns at a negedge back in IDLE.
  task automatic run_op(input string name, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp, input int exp_lat,
                        input bit hold, input bit scramble);
    int cyc;
    bit got;
    a = av;
    b = bv;
    init_in = 1'b1;
    @(posedge clk);
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!hold) init_in = 1'b0;
      if (scramble) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (done) got = 1'b1;
    end
    chk({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({name, "_result"}, result, exp);
    $display("op %s A=%h B=%h Result=%h latency=%0d", name, av, bv, result, cyc);
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        chk({name, "_hold_done"}, {31'd0, done}, 32'd1);
        chk({name, "_hold_result"}, result, exp);
      end
    end
    @(negedge clk);
    init_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    repeat (3) @(negedge clk);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    run_op("basic", 16'd3, 16'd5, 32'h0000000F, EE ? 3 : 16, 1'b0, 1'b0);
    run_op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 1'b1, 1'b0);
    run_op("zero_b", 16'h1234, 16'h0000, 32'h0, EE ? 1 : 16, 1'b0, 1'b0);

    // Reset in the middle of a run.
    a = 16'h00FF;
    b = 16'h0101;
    init_in = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      init_in = 1'b0;
      @(posedge clk);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("midreset_done", {31'd0, done}, 32'd0);
    chk("midreset_result", result, 32'd0);
    $display("op midreset Result=%h done=%b", result, done);
    @(negedge clk);
    rst = 1'b1;
    run_op("after_reset", 16'd7, 16'd9, 32'd63, EE ? 4 : 16, 1'b0, 1'b0);

    run_op("b2b_first", 16'h1234, 16'h5678, 32'h06260060, EE ? 15 : 16, 1'b0, 1'b0);
    run_op("b2b_second", 16'd2, 16'h8000, 32'h00010000, 16, 1'b0, 1'b0);
    run_op("stability", 16'd100, 16'd200, 32'd20000, EE ? 8 : 16, 1'b0, 1'b1);
    run_op("zero_a", 16'h0000, 16'hBEEF, 32'h0, exp_latency(16'hBEEF), 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 3 == 1) rb = rb >> $urandom_range(15, 0);
      run_op("random", ra, rb, {16'h0000, ra} * {16'h0000, rb}, exp_latency(rb),
             1'b0, n % 4 == 2);
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
